// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e      : controller states (RUN, MEM_WAIT, FLUSH, ERROR)
//   - FWD_*        : ALU operand source selects driven on ForwardA/ForwardB
//   - ex_rec_t     : shadow record of the instruction currently in EX
//   - mem_rec_t    : shadow record of the instruction currently in MEM
//   - reg_match()  : register-dependency compare that never matches x0
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from the EX/MEM result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from the MEM/WB result

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       load;
    logic       mem;
  } ex_rec_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       mem;
  } mem_rec_t;

  // x0 is hard-wired to zero, so a write to it is never a real producer.
  function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
    return (rd != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Operand forwarding select for one ALU source register. The youngest producer
// (EX) wins over the older one (MEM). A load in EX cannot forward: its data does
// not exist yet, and the load-use stall covers that case instead.
//
// Ports:
//   i_rs        in  5  source register of the instruction in ID
//   i_ex_rd     in  5  destination of the instruction in EX
//   i_ex_wr     in  1  EX instruction writes its destination
//   i_ex_load   in  1  EX instruction is a load
//   i_mem_rd    in  5  destination of the instruction in MEM
//   i_mem_wr    in  1  MEM instruction writes its destination
//   o_sel       out 2  FWD_REG / FWD_EXMEM / FWD_MEMWB
// -----------------------------------------------------------------------------
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_wr,
  input  logic       i_ex_load,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_wr,
  output logic [1:0] o_sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives o_sel; no latch is inferred.
    o_sel = FWD_REG;
    if (i_ex_wr && !i_ex_load && reg_match(i_rs, i_ex_rd)) begin
      o_sel = FWD_EXMEM;
    end else if (i_mem_wr && reg_match(i_rs, i_mem_rd)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and stall controller for a 5-stage in-order pipeline. Keeps shadow
// records of the instructions in EX and MEM, stalls on data-memory latency and
// load-use dependencies, flushes on a redirect resolved in EX, selects ALU
// operand forwarding, and raises a sticky error when the data memory fails to
// acknowledge within TIMEOUT wait cycles.
//
// Parameter:
//   TIMEOUT      max MEM_WAIT cycles without DmemAck before entering ERROR
//
// Ports:
//   CLK          in   1  clock, rising edge
//   RST          in   1  synchronous active-high reset
//   IDrs1/2, IDrd in  5  register fields of the instruction in ID
//   IDUse1/2     in   1  ID reads rs1 / rs2
//   IDRegWrite   in   1  ID writes rd
//   IDMemRead    in   1  ID is a load
//   IDMemAccess  in   1  ID touches data memory
//   Redirect     in   1  taken branch/jump resolved in EX
//   DmemAck      in   1  data-memory completion for the access in MEM
//   PCWriteEn    out  1  PC advance enable
//   IFIDWriteEn  out  1  IF/ID advance enable
//   IFIDFlush    out  1  zero the IF/ID register
//   IDEXBubble   out  1  load a NOP into ID/EX
//   DmemReq      out  1  data-memory request for the access in MEM
//   ForwardA/B   out  2  ALU operand source for rs1 / rs2
//   Err          out  1  sticky data-memory timeout flag
// -----------------------------------------------------------------------------
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] IDrs1,
  input  logic [4:0] IDrs2,
  input  logic [4:0] IDrd,
  input  logic       IDUse1,
  input  logic       IDUse2,
  input  logic       IDRegWrite,
  input  logic       IDMemRead,
  input  logic       IDMemAccess,
  input  logic       Redirect,
  input  logic       DmemAck,
  output logic       PCWriteEn,
  output logic       IFIDWriteEn,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       DmemReq,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       Err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e           r_state;
  ex_rec_t          r_ex;
  mem_rec_t         r_mem;
  logic [CNT_W-1:0] r_cnt;
  // A redirect seen while the pipeline is frozen is remembered and applied on
  // the cycle the stall ends, even if the input has dropped by then.
  logic             r_redir_pend;

  logic    w_stall;      // pipeline frozen this cycle by the data memory
  logic    w_go;         // pipeline advances this cycle
  logic    w_redir;      // redirect applied this cycle
  logic    w_load_use;   // load-use bubble inserted this cycle
  ex_rec_t w_ex_next;

  // ---------------------------------------------------------------------------
  // Stall / flush decisions (priority: ERROR > Dmem stall > redirect > load-use)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stall = 1'b0;
    w_go    = 1'b0;
    unique case (r_state)
      ST_RUN, ST_FLUSH: begin
        w_stall = r_mem.mem && !DmemAck;
        w_go    = !w_stall;
      end
      ST_MEM_WAIT: begin
        w_stall = !DmemAck;
        w_go    = DmemAck;
      end
      default: ;  // ERROR: everything frozen
    endcase

    // The cycle after a flush carries the squashed slot; its Redirect is stale.
    w_redir    = w_go && (r_redir_pend || (Redirect && (r_state != ST_FLUSH)));
    w_load_use = w_go && !w_redir && r_ex.load &&
                 ((IDUse1 && reg_match(IDrs1, r_ex.rd)) ||
                  (IDUse2 && reg_match(IDrs2, r_ex.rd)));

    if (w_redir || w_load_use) begin
      w_ex_next = '0;
    end else begin
      w_ex_next = '{rd: IDrd, wr: IDRegWrite, load: IDMemRead, mem: IDMemAccess};
    end
  end

  assign PCWriteEn   = w_go && !w_load_use;
  assign IFIDWriteEn = w_go && !w_load_use;
  assign IFIDFlush   = w_redir;
  assign IDEXBubble  = w_redir || w_load_use;
  assign DmemReq     = (r_state == ST_MEM_WAIT) ||
                       (((r_state == ST_RUN) || (r_state == ST_FLUSH)) && r_mem.mem);
  assign Err         = (r_state == ST_ERROR);

  // ---------------------------------------------------------------------------
  // Forwarding selects, one compare unit per ALU source
  // ---------------------------------------------------------------------------
  fwd_sel u_fwd_a (
    .i_rs      (IDrs1),
    .i_ex_rd   (r_ex.rd),
    .i_ex_wr   (r_ex.wr),
    .i_ex_load (r_ex.load),
    .i_mem_rd  (r_mem.rd),
    .i_mem_wr  (r_mem.wr),
    .o_sel     (ForwardA)
  );

  fwd_sel u_fwd_b (
    .i_rs      (IDrs2),
    .i_ex_rd   (r_ex.rd),
    .i_ex_wr   (r_ex.wr),
    .i_ex_load (r_ex.load),
    .i_mem_rd  (r_mem.rd),
    .i_mem_wr  (r_mem.wr),
    .o_sel     (ForwardB)
  );

  // ---------------------------------------------------------------------------
  // State, shadow records and wait counter
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_RUN;
      r_ex         <= '0;
      r_mem        <= '0;
      r_cnt        <= '0;
      r_redir_pend <= 1'b0;
    end else begin
      if (w_go) begin
        r_ex  <= w_ex_next;
        r_mem <= '{rd: r_ex.rd, wr: r_ex.wr, mem: r_ex.mem};
      end

      unique case (r_state)
        ST_RUN, ST_FLUSH: begin
          r_cnt <= '0;
          if (w_stall) begin
            r_state      <= ST_MEM_WAIT;
            r_redir_pend <= Redirect && (r_state == ST_RUN);
          end else if (w_redir) begin
            r_state <= ST_FLUSH;
          end else begin
            r_state <= ST_RUN;
          end
        end

        ST_MEM_WAIT: begin
          if (DmemAck) begin
            r_cnt        <= '0;
            r_redir_pend <= 1'b0;
            r_state      <= w_redir ? ST_FLUSH : ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (Redirect) begin
              r_redir_pend <= 1'b1;
            end
            if (int'(r_cnt) + 1 >= TIMEOUT) begin
              r_state <= ST_ERROR;
            end
          end
        end

        default: r_state <= ST_ERROR;  // sticky until reset
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed per-cycle stimulus for hazard_ctrl. Each stimulus cycle pushes the
// hand-derived control outputs for that cycle into a scoreboard queue; an
// independent monitor pops and compares on the falling edge.
// Output vector layout: {PCWriteEn, IFIDWriteEn, IFIDFlush, IDEXBubble,
//                        DmemReq, Err, ForwardA[1:0], ForwardB[1:0]}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] IDrs1, IDrs2, IDrd;
  logic       IDUse1, IDUse2, IDRegWrite, IDMemRead, IDMemAccess;
  logic       Redirect, DmemAck;
  logic       PCWriteEn, IFIDWriteEn, IFIDFlush, IDEXBubble, DmemReq, Err;
  logic [1:0] ForwardA, ForwardB;

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use1;
    logic       use2;
    logic       wr;
    logic       load;
    logic       mem;
  } id_t;

  typedef struct {
    string      name;
    logic [9:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_ctrl #(.TIMEOUT(15)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IDrs1       (IDrs1),
    .IDrs2       (IDrs2),
    .IDrd        (IDrd),
    .IDUse1      (IDUse1),
    .IDUse2      (IDUse2),
    .IDRegWrite  (IDRegWrite),
    .IDMemRead   (IDMemRead),
    .IDMemAccess (IDMemAccess),
    .Redirect    (Redirect),
    .DmemAck     (DmemAck),
    .PCWriteEn   (PCWriteEn),
    .IFIDWriteEn (IFIDWriteEn),
    .IFIDFlush   (IFIDFlush),
    .IDEXBubble  (IDEXBubble),
    .DmemReq     (DmemReq),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .Err         (Err)
  );

  // ---- instruction builders -------------------------------------------------
  function automatic id_t nop();
    return '0;
  endfunction

  function automatic id_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{rs1: rs1, rs2: rs2, rd: rd, use1: 1'b1, use2: 1'b1, wr: 1'b1, load: 1'b0, mem: 1'b0};
  endfunction

  // Immediate-form ALU op: rs2 field carries immediate bits and is not read.
  function automatic id_t imm(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
    return '{rs1: rs1, rs2: rs2f, rd: rd, use1: 1'b1, use2: 1'b0, wr: 1'b1, load: 1'b0, mem: 1'b0};
  endfunction

  function automatic id_t ld(input logic [4:0] rd, input logic [4:0] rs1);
    return '{rs1: rs1, rs2: 5'd0, rd: rd, use1: 1'b1, use2: 1'b0, wr: 1'b1, load: 1'b1, mem: 1'b1};
  endfunction

  function automatic logic [9:0] o(input logic pc, input logic ifid, input logic fl,
                                   input logic bub, input logic req, input logic err,
                                   input logic [1:0] fa, input logic [1:0] fb);
    return {pc, ifid, fl, bub, req, err, fa, fb};
  endfunction

  // ---- stimulus: one call = one clock cycle ---------------------------------
  task automatic cyc(input string name, input id_t ins, input logic redir,
                     input logic ack, input logic rst, input logic [9:0] val);
    @(posedge CLK);
    #1;
    RST         = rst;
    IDrs1       = ins.rs1;
    IDrs2       = ins.rs2;
    IDrd        = ins.rd;
    IDUse1      = ins.use1;
    IDUse2      = ins.use2;
    IDRegWrite  = ins.wr;
    IDMemRead   = ins.load;
    IDMemAccess = ins.mem;
    Redirect    = redir;
    DmemAck     = ack;
    sb.push_back('{name: name, val: val});
  endtask

  // ---- monitor ----------------------------------------------------------------
  initial begin : monitor
    exp_t       e;
    logic [9:0] got;
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        got = {PCWriteEn, IFIDWriteEn, IFIDFlush, IDEXBubble, DmemReq, Err, ForwardA, ForwardB};
        n_checks++;
        if (got !== e.val) begin
          n_errors++;
          $display("FAIL %s: actual=%b required=%b (pc,ifid,flush,bubble,req,err,fa,fb)",
                   e.name, got, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---- directed sequence ------------------------------------------------------
  localparam logic [1:0] F0 = 2'b00, F1 = 2'b01, F2 = 2'b10;

  initial begin : stim
    RST = 1'b1; IDrs1 = '0; IDrs2 = '0; IDrd = '0;
    IDUse1 = 1'b0; IDUse2 = 1'b0; IDRegWrite = 1'b0; IDMemRead = 1'b0; IDMemAccess = 1'b0;
    Redirect = 1'b0; DmemAck = 1'b0;
    repeat (2) @(posedge CLK);

    cyc("reset_vals", nop(), 0, 0, 1, o(1,1,0,0,0,0,F0,F0));

    // ALU-to-ALU forwarding, EX over MEM priority
    cyc("add_x5",        alu(5,1,2), 0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("sub_x7_x5_x5",  alu(7,5,5), 0, 0, 0, o(1,1,0,0,0,0,F1,F1));
    cyc("ex_and_mem_fw", alu(7,7,5), 0, 0, 0, o(1,1,0,0,0,0,F1,F2));
    cyc("ex_priority",   alu(1,7,0), 0, 0, 0, o(1,1,0,0,0,0,F1,F0));

    // x0 never forwards or stalls
    cyc("wr_x0",         alu(0,3,4), 0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("use_x0_ex",     alu(2,0,0), 0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("use_x0_mem",    alu(3,0,0), 0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("ld_x0",         ld(0,1),    0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("use_ld_x0",     alu(4,0,0), 0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("ld_x0_mem_ack", nop(),      0, 1, 0, o(1,1,0,0,1,0,F0,F0));
    cyc("drain0",        nop(),      0, 0, 0, o(1,1,0,0,0,0,F0,F0));

    // load-use: one bubble, then MEM/WB forward
    cyc("lw_x5",         ld(5,1),     0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("lu_stall",      alu(6,5,1),  0, 0, 0, o(0,0,0,1,0,0,F0,F0));
    cyc("lu_resume",     alu(6,5,1),  0, 1, 0, o(1,1,0,0,1,0,F2,F0));
    cyc("lw_x8",         ld(8,2),     0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("rs2_unused",    imm(9,3,8),  0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("lw_x8_ack",     nop(),       0, 1, 0, o(1,1,0,0,1,0,F0,F0));
    cyc("drain1",        nop(),       0, 0, 0, o(1,1,0,0,0,0,F0,F0));

    // Dmem ack delayed 3 cycles
    cyc("dm_ld",         ld(5,1),      0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("dm_indep",      alu(10,2,3),  0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("dm_frz1",       alu(11,5,10), 0, 0, 0, o(0,0,0,0,1,0,F2,F1));
    cyc("dm_frz2",       alu(11,5,10), 0, 0, 0, o(0,0,0,0,1,0,F2,F1));
    cyc("dm_frz3",       alu(11,5,10), 0, 0, 0, o(0,0,0,0,1,0,F2,F1));
    cyc("dm_ack",        alu(11,5,10), 0, 1, 0, o(1,1,0,0,1,0,F2,F1));
    cyc("drain2",        nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("drain3",        nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));

    // Redirect: flush one cycle, second Redirect ignored in FLUSH
    cyc("redir",         alu(12,1,2),  1, 0, 0, o(1,1,1,1,0,0,F0,F0));
    cyc("redir_ignored", nop(),        1, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("post_flush",    alu(13,1,2),  0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("redir_fwd",     alu(14,13,1), 1, 0, 0, o(1,1,1,1,0,0,F1,F0));
    cyc("flush_cyc",     nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("rl_ld",         ld(15,1),     0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("redir_over_lu", alu(16,15,15),1, 0, 0, o(1,1,1,1,0,0,F0,F0));
    cyc("flush_mem_ack", nop(),        0, 1, 0, o(1,1,0,0,1,0,F0,F0));

    // Redirect during a Dmem stall is applied when the stall ends
    cyc("sr_ld",         ld(17,1),     0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("sr_alu",        alu(18,2,3),  0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("sr_stall_redir",alu(19,1,2),  1, 0, 0, o(0,0,0,0,1,0,F0,F0));
    cyc("sr_wait",       alu(19,1,2),  0, 0, 0, o(0,0,0,0,1,0,F0,F0));
    cyc("sr_ack_flush",  alu(19,1,2),  0, 1, 0, o(1,1,1,1,1,0,F0,F0));
    cyc("sr_flush_cyc",  nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));

    // Dmem never acks: 15 wait cycles, then sticky Err until RST
    cyc("to_ld",         ld(20,1),     0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("to_nop",        nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("to_stall",      nop(),        0, 0, 0, o(0,0,0,0,1,0,F0,F0));
    for (int k = 1; k <= 15; k++) begin
      cyc($sformatf("to_wait%0d", k), nop(), 0, 0, 0, o(0,0,0,0,1,0,F0,F0));
    end
    cyc("err_set",       nop(),        0, 0, 0, o(0,0,0,0,0,1,F0,F0));
    cyc("err_hold_ack",  nop(),        1, 1, 0, o(0,0,0,0,0,1,F0,F0));
    cyc("err_hold",      nop(),        0, 0, 0, o(0,0,0,0,0,1,F0,F0));
    cyc("err_rst_cyc",   nop(),        0, 0, 1, o(0,0,0,0,0,1,F0,F0));
    cyc("err_cleared",   nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));

    // RST in MEM_WAIT abandons the access
    cyc("mr_ld",         ld(21,1),     0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("mr_nop",        nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("mr_stall",      nop(),        0, 0, 0, o(0,0,0,0,1,0,F0,F0));
    cyc("mr_rst_cyc",    nop(),        0, 0, 1, o(0,0,0,0,1,0,F0,F0));
    cyc("mr_req_drop",   nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));
    cyc("mr_clean",      nop(),        0, 0, 0, o(1,1,0,0,0,0,F0,F0));

    @(negedge CLK);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
